// File: rtl/param_facto_core.sv
// Bus-mapped n! / n!! engine built around a shift-add sequential multiplier.
// Define PFC_OVF_SAT_EN to saturate the result to all ones and stop at the first overflowing step.
module param_facto_core #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h7000,
  parameter int                RES_W     = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  // state   | meaning
  // S_IDLE  | waiting for OPSTART
  // S_INIT  | acc = 1, k = operand, overflow cleared
  // S_CHECK | k <= 1 finishes, otherwise load the multiplier
  // S_MUL   | one multiplier bit per cycle, acc * k
  // S_DONE  | result valid, held until OPCLEAR

  localparam int NW = RES_W / DATA_W;
  localparam int PW = RES_W + DATA_W;

  localparam logic [ADDR_W-1:0] OFF_START   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_CLEAR   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OFF_STATUS  = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] OFF_INTREN  = ADDR_W'(8'h18);
  localparam logic [ADDR_W-1:0] OFF_OPERAND = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] OFF_MODE    = ADDR_W'(8'h28);
  localparam logic [ADDR_W-1:0] OFF_RESULT  = ADDR_W'(8'h40);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_CHECK, S_MUL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [RES_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   k_q, k_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                intr_en_q, intr_en_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic                mode_q, mode_d;

  logic                in_range;
  logic [ADDR_W-1:0]   off;
  logic                wr;
  logic                busy;
  logic [PW-1:0]       sum;
  logic [DATA_W-1:0]   dec;
  logic                step_ovf;

  assign in_range = (s_addr >= BASE_ADDR);
  assign off      = s_addr - BASE_ADDR;
  assign wr       = s_sel & s_wr & in_range;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr && in_range) begin
      case (off)
        OFF_STATUS:  s_dout = DATA_W'({busy, ovf_q, done_q});
        OFF_INTREN:  s_dout = DATA_W'(intr_en_q);
        OFF_OPERAND: s_dout = operand_q;
        OFF_MODE:    s_dout = DATA_W'(mode_q);
        default:     ;
      endcase
      for (int i = 0; i < NW; i++) begin
        if (off == OFF_RESULT + ADDR_W'(8 * i)) s_dout = result_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_d       = k_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    result_d  = result_q;
    intr_en_d = intr_en_q;
    operand_d = operand_q;
    mode_d    = mode_q;
    sum       = prod_q + (mplier_q[0] ? mcand_q : '0);
    dec       = mode_q ? DATA_W'(2) : DATA_W'(1);
    step_ovf  = |sum[PW-1:RES_W];

    if (wr && off == OFF_INTREN) intr_en_d = s_din[0];
    if (wr && off == OFF_OPERAND && !busy) operand_d = s_din;
    if (wr && off == OFF_MODE && !busy) mode_d = s_din[0];

    case (state_q)
      S_IDLE: begin
        if (wr && off == OFF_START && s_din[0]) state_d = S_INIT;
      end
      S_INIT: begin
        acc_d   = RES_W'(1);
        k_d     = operand_q;
        ovf_d   = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (k_q <= DATA_W'(1)) begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          mplier_d = k_q;
          mcand_d  = PW'(acc_q);
          prod_d   = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        prod_d   = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Stop as soon as no set bits remain above the one just consumed.
        if ((mplier_q >> 1) == '0) begin
          acc_d   = sum[RES_W-1:0];
          ovf_d   = ovf_q | step_ovf;
          k_d     = (k_q > dec) ? k_q - dec : '0;
          state_d = S_CHECK;
`ifdef PFC_OVF_SAT_EN
          if (step_ovf) begin
            acc_d    = '1;
            result_d = '1;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // Clear wins over everything and aborts any computation in flight.
    if (wr && off == OFF_CLEAR && s_din[0]) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      k_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      intr_en_q <= 1'b0;
      operand_q <= '0;
      mode_q    <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      result_q  <= result_d;
      intr_en_q <= intr_en_d;
      operand_q <= operand_d;
      mode_q    <= mode_d;
      interrupt <= done_d & intr_en_d;
    end
  end

endmodule

// File: tb/tb_param_facto_core.sv
// Directed and random checks of param_facto_core against a plain-arithmetic factorial model.
module tb_param_facto_core;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam int RES_W  = 128;
  localparam logic [15:0] A_START   = 16'h7000;
  localparam logic [15:0] A_CLEAR   = 16'h7008;
  localparam logic [15:0] A_STATUS  = 16'h7010;
  localparam logic [15:0] A_INTREN  = 16'h7018;
  localparam logic [15:0] A_OPERAND = 16'h7020;
  localparam logic [15:0] A_MODE    = 16'h7028;
  localparam logic [15:0] A_RES0    = 16'h7040;
  localparam logic [15:0] A_RES1    = 16'h7048;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  param_facto_core #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(16'h7000), .RES_W(RES_W)
  ) dut (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit irq_early);
    logic [63:0] st;
    cyc = -1;
    irq_early = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      rd(A_STATUS, st);
      if (st[0]) begin
        cyc = c;
        break;
      end
      if (interrupt) irq_early = 1'b1;
    end
  endtask

  // Multiply down from n in steps of 1 or 2; each step costs one check cycle plus bitlen(k).
  function automatic void model(input int n, input bit m, output logic [127:0] res,
                                output bit ovf, output int lat);
    logic [255:0] a;
    int k;
    a = 256'd1;
    ovf = 1'b0;
    lat = 2;
    k = n;
    while (k > 1) begin
      a = a * 256'(k);
      lat += $clog2(k + 1) + 1;
      if (a[255:128] != '0) begin
        ovf = 1'b1;
`ifdef PFC_OVF_SAT_EN
        res = '1;
        lat = lat - 1;
        return;
`else
        a[255:128] = '0;
`endif
      end
      k -= m ? 2 : 1;
    end
    res = a[127:0];
  endfunction

  task automatic run_case(input int n, input bit m, input bit ien, output int lat_o);
    logic [127:0] exp_res;
    bit           exp_ovf;
    int           exp_lat;
    int           cyc;
    bit           early;
    logic [63:0]  r0, r1, st;
    string        t;
    t = $sformatf("n%0d_m%0d_ie%0d", n, m, ien);
    model(n, m, exp_res, exp_ovf, exp_lat);
    wr(A_CLEAR, 64'd1);
    wr(A_OPERAND, 64'(n));
    wr(A_MODE, 64'(m));
    wr(A_INTREN, 64'(ien));
    wr(A_START, 64'd1);
    wait_done(6000, cyc, early);
    check({t, "_irq_now"}, interrupt, ien);
    check({t, "_irq_early"}, early, 1'b0);
    check({t, "_latency"}, cyc, exp_lat);
    rd(A_RES0, r0);
    rd(A_RES1, r1);
    rd(A_STATUS, st);
    check({t, "_result"}, {r1, r0}, exp_res);
    check({t, "_status"}, st, {61'd0, 1'b0, exp_ovf, 1'b1});
    lat_o = cyc;
  endtask

  initial begin
    logic [63:0] d;
    int lat, cyc, n;
    bit early, irq_seen, m, ien;

    reset = 1'b1; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    check("rst_irq", interrupt, 1'b0);
    check("rst_dout_idle", s_dout, 64'd0);
    rd(A_STATUS, d);  check("rst_status", d, 64'd0);
    rd(A_RES0, d);    check("rst_res0", d, 64'd0);
    rd(A_OPERAND, d); check("rst_operand", d, 64'd0);
    rd(A_INTREN, d);  check("rst_intren", d, 64'd0);

    run_case(5, 1'b0, 1'b1, lat);
    check("f5_latency16", lat, 16);
    rd(A_RES0, d);   check("f5_res0", d, 64'd120);
    rd(A_RES1, d);   check("f5_res1", d, 64'd0);
    rd(A_STATUS, d); check("f5_status", d, 64'h1);

    run_case(10, 1'b0, 1'b1, lat);
    rd(A_RES0, d); check("f10_res0", d, 64'd3628800);
    run_case(20, 1'b1, 1'b1, lat);
    rd(A_RES0, d);   check("df20_res0", d, 64'd3715891200);
    rd(A_STATUS, d); check("df20_ovf", d[1], 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_case(i & 1, i[1], i[2], lat);
      check($sformatf("small%0d_lat2", i), lat, 2);
    end

    run_case(34, 1'b0, 1'b1, lat);
    rd(A_STATUS, d); check("f34_ovf", d[1], 1'b0);
    run_case(35, 1'b0, 1'b1, lat);
    rd(A_STATUS, d); check("f35_ovf", d[1], 1'b1);
`ifdef PFC_OVF_SAT_EN
    rd(A_RES0, d); check("f35_sat_res0", d, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_RES1, d); check("f35_sat_res1", d, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // Abort a long computation
    wr(A_CLEAR, 64'd1);
    wr(A_OPERAND, 64'd68);
    wr(A_MODE, 64'd0);
    wr(A_INTREN, 64'd1);
    wr(A_START, 64'd1);
    irq_seen = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (interrupt) irq_seen = 1'b1;
    end
    rd(A_STATUS, d); check("abort_busy_before", d, 64'h4);
    wr(A_CLEAR, 64'd1);
    rd(A_STATUS, d); check("abort_status", d, 64'd0);
    rd(A_RES0, d);   check("abort_res0", d, 64'd0);
    rd(A_RES1, d);   check("abort_res1", d, 64'd0);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (interrupt) irq_seen = 1'b1;
    end
    check("abort_irq", irq_seen, 1'b0);
    rd(A_STATUS, d); check("abort_status_later", d, 64'd0);

    // Unmapped and unaligned accesses
    wr(A_OPERAND, 64'd7);
    wr(A_MODE, 64'd1);
    wr(16'h70FF, 64'h55);
    wr(16'h7030, 64'h3);
    wr(16'h7021, 64'd9);
    wr(16'h6FF8, 64'd1);
    rd(A_OPERAND, d); check("unmap_operand", d, 64'd7);
    rd(A_MODE, d);    check("unmap_mode", d, 64'd1);
    rd(16'h70FF, d);  check("unmap_rd_70ff", d, 64'd0);
    rd(16'h7030, d);  check("unmap_rd_7030", d, 64'd0);
    rd(A_STATUS, d);  check("unmap_status", d, 64'd0);

    // Writes while busy are ignored
    wr(A_CLEAR, 64'd1);
    wr(A_OPERAND, 64'd5);
    wr(A_MODE, 64'd0);
    wr(A_INTREN, 64'd1);
    wr(A_START, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    wr(A_START, 64'd1);
    wr(A_OPERAND, 64'd9);
    wr(A_MODE, 64'd1);
    wait_done(500, cyc, early);
    check("busywr_latency", (cyc < 0) ? -1 : 8 + cyc, 16);
    rd(A_RES0, d);    check("busywr_res0", d, 64'd120);
    rd(A_OPERAND, d); check("busywr_operand", d, 64'd5);
    rd(A_MODE, d);    check("busywr_mode", d, 64'd0);
    check("busywr_irq", interrupt, 1'b1);

    wr(A_INTREN, 64'd0);
    check("intren0_irq", interrupt, 1'b0);
    rd(A_STATUS, d); check("intren0_done_kept", d, 64'h1);
    wr(A_START, 64'd1);
    rd(A_RES0, d);   check("done_start_ignored", d, 64'd120);

    // Reset in the middle of a computation
    wr(A_CLEAR, 64'd1);
    wr(A_INTREN, 64'd1);
    wr(A_OPERAND, 64'd12);
    wr(A_START, 64'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(A_STATUS, d);  check("midrst_status", d, 64'd0);
    rd(A_OPERAND, d); check("midrst_operand", d, 64'd0);
    irq_seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (interrupt) irq_seen = 1'b1;
    end
    check("midrst_irq", irq_seen, 1'b0);
    rd(A_STATUS, d); check("midrst_status_later", d, 64'd0);

    for (int i = 0; i < 14; i++) begin
      n = $urandom_range(0, 45);
      m = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      run_case(n, m, ien, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
